equal_cmp_pipe: RTL and testbench
=================================

EQUAL_CMP_PIPE -- requirements
Module: equal_cmp_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, as the operand width in bits; legal values are powers of two from 2 to 128.
REQ-002 The block SHALL have a localparam LEVELS = log2(WIDTH), the number of reduction-tree levels.
REQ-003 The block SHALL have the following ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  the operand pair is presented.
- in_ready  out  1  the block accepts this cycle.
- x  in  WIDTH  first operand.
- y  in  WIDTH  second operand.
- signed_mode  in  1  1 = two's-complement compare; 0 = unsigned compare.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the consumer accepts the result.
- equal  out  1  x == y.
- less  out  1  x < y under the captured mode.
- greater  out  1  x > y under the captured mode.

Function
REQ-004 A transfer SHALL occur on an edge when in_valid && in_ready; a result SHALL retire on an edge when out_valid && out_ready.
REQ-005 The pipeline SHALL have LEVELS+1 register stages: stage 0 registers per-bit (eq_i, gt_i) pairs; stage k (1..LEVELS) registers one pairwise tree merge.
REQ-006 Merge rule: eq = eq_hi & eq_lo; gt = gt_hi | (eq_hi & gt_lo); the upper half SHALL dominate.
REQ-007 Per-bit terms: eq_i = x[i] XNOR y[i]; gt_i = x[i] & ~y[i]; in signed mode the MSB term SHALL use gt = ~x[MSB] & y[MSB].
REQ-008 The outputs SHALL be: equal = eq; greater = gt; less = ~eq & ~gt; exactly one SHALL be high whenever out_valid=1.
REQ-009 Each stage SHALL carry a valid bit; latency from the accepting edge to out_valid=1 SHALL be LEVELS+1 cycles (6 for WIDTH=32) with no stall.
REQ-010 The pipeline SHALL advance as a whole when adv = ~out_valid | out_ready; when adv=0, every stage SHALL hold its data and valid bits.
REQ-011 in_ready SHALL equal adv (combinational); full throughput is one result per cycle while out_ready=1.
REQ-012 Bubbles (invalid stages) SHALL propagate, and no result SHALL be duplicated or dropped under any in_valid/out_ready pattern.
REQ-013 signed_mode SHALL be sampled only at transfer; a change while an operation is in flight SHALL NOT affect it.
REQ-014 The data path SHALL hold the previous values when out_valid=0; the bench SHALL NOT check equal, less or greater then.

Reset
REQ-015 When rst=1 at an edge, all stage valid bits SHALL clear, so that out_valid=0 on the next cycle.
REQ-016 When rst=1 at an edge, equal/less/greater SHALL be 0, and in_ready SHALL read 1 after that edge.
REQ-017 Reset SHALL discard in-flight operations without emitting them; a transfer coinciding with rst=1 SHALL be dropped.

Configuration
REQ-018 When macro EQUAL_CMP_PIPE_STATS_EN is defined, the block SHALL add ports stat_clr (in, 1) and eq_count (out, 32).
REQ-019 With the macro defined, eq_count SHALL increment on each retire with equal=1, saturate at 32'hFFFF_FFFF, and clear on rst or stat_clr.
REQ-020 stat_clr SHALL take priority over a simultaneous increment.
REQ-021 When the macro is undefined, these ports and the counter SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-022 WIDTH=32, out_ready=1, x=y=32'hDEADBEEF -> equal=1 exactly 6 cycles after the transfer; less=greater=0.
REQ-023 Signed compare: x=32'hFFFFFFFF, y=32'h00000001, signed_mode=1 -> less=1; the same operands with signed_mode=0 -> greater=1.
REQ-024 Back-to-back throughput: 10 consecutive transfers with out_ready held 1 -> 10 in-order results on consecutive cycles.
REQ-025 Backpressure: hold out_ready=0 for 4 cycles with a result pending -> the outputs are stable, in_ready=0, and no loss or duplication occurs after release.
REQ-026 Reset mid-flight: assert rst with 3 operations in flight -> out_valid=0 on the next cycle, and none of the 3 appear afterwards.
REQ-027 STATS_EN: retire 3 equal and 2 unequal results -> eq_count=3; stat_clr together with an equal retire -> eq_count=0.

Source files
------------

// File: rtl/equal_cmp_pipe.sv
// Pipelined equal/less/greater comparator: per-bit terms, then a log2(WIDTH) merge tree.
// Optional statistics counter enabled by EQUAL_CMP_PIPE_STATS_EN (adds stat_clr, eq_count).
module equal_cmp_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             equal,
  output logic             less,
  output logic             greater
`ifdef EQUAL_CMP_PIPE_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      eq_count
`endif
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  // All levels packed into one vector: level k occupies WIDTH>>k bits at 2*WIDTH-2*(WIDTH>>k).
  localparam int unsigned TBITS  = 2 * WIDTH - 1;

  logic [TBITS-1:0] eq_q, gt_q, eq_d, gt_d;
  logic [LEVELS:0]  vld_q;
  logic             shown_q;
  logic             adv;
  logic [WIDTH-1:0] eq0, gt0;

  assign adv      = ~vld_q[LEVELS] | out_ready;
  assign in_ready = adv;

  always_comb begin
    eq0 = ~(x ^ y);
    gt0 = x & ~y;
    if (signed_mode) begin
      gt0[WIDTH-1] = ~x[WIDTH-1] & y[WIDTH-1];
    end
  end

  assign eq_d[WIDTH-1:0] = (adv && in_valid) ? eq0 : eq_q[WIDTH-1:0];
  assign gt_d[WIDTH-1:0] = (adv && in_valid) ? gt0 : gt_q[WIDTH-1:0];

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned N    = WIDTH >> k;
    localparam int unsigned IOFF = 2 * WIDTH - 2 * (WIDTH >> (k - 1));
    localparam int unsigned OOFF = 2 * WIDTH - 2 * N;
    logic [N-1:0] eq_m, gt_m;
    for (genvar j = 0; j < N; j++) begin : g_pair
      // Upper half dominates: it decides unless it is equal.
      assign eq_m[j] = eq_q[IOFF+2*j+1] & eq_q[IOFF+2*j];
      assign gt_m[j] = gt_q[IOFF+2*j+1] | (eq_q[IOFF+2*j+1] & gt_q[IOFF+2*j]);
    end
    assign eq_d[OOFF +: N] = (adv && vld_q[k-1]) ? eq_m : eq_q[OOFF +: N];
    assign gt_d[OOFF +: N] = (adv && vld_q[k-1]) ? gt_m : gt_q[OOFF +: N];
  end

  always_ff @(posedge clk) begin
    eq_q <= eq_d;
    gt_q <= gt_d;
  end

  // shown_q keeps the outputs at zero from reset until the first result lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      shown_q <= 1'b0;
    end else if (adv) begin
      vld_q <= {vld_q[LEVELS-1:0], in_valid};
      if (vld_q[LEVELS-1]) begin
        shown_q <= 1'b1;
      end
    end
  end

  assign out_valid = vld_q[LEVELS];
  assign equal     = shown_q & eq_q[TBITS-1];
  assign greater   = shown_q & gt_q[TBITS-1];
  assign less      = shown_q & ~eq_q[TBITS-1] & ~gt_q[TBITS-1];

`ifdef EQUAL_CMP_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      eq_count <= '0;
    end else if (out_valid && out_ready && equal && (eq_count != 32'hFFFF_FFFF)) begin
      eq_count <= eq_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_equal_cmp_pipe.sv
// Directed, table-driven bench for equal_cmp_pipe (WIDTH=32), plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_equal_cmp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x, y;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic        equal, less, greater;
`ifdef EQUAL_CMP_PIPE_STATS_EN
  logic        stat_clr;
  logic [31:0] eq_count;
`endif

  int checks   = 0;
  int failures = 0;

  equal_cmp_pipe #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .equal      (equal),
    .less       (less),
    .greater    (greater)
`ifdef EQUAL_CMP_PIPE_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .eq_count   (eq_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vx;
    logic [31:0] vy;
    logic        sm;
    logic [2:0]  exp; // {equal, less, greater}
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                         input logic sm);
    logic lt;
    lt = sm ? ($signed(a) < $signed(b)) : (a < b);
    return {a == b, lt, (a != b) && !lt};
  endfunction

  // Present one operand pair on an empty pipe; flip signed_mode right after acceptance.
  task automatic apply_one(input logic [31:0] ax, input logic [31:0] ay, input logic asm,
                           output logic [2:0] res, output int lat);
    x = ax; y = ay; signed_mode = asm; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    signed_mode = ~asm;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    res = {equal, less, greater};
  endtask

  initial begin
    logic [2:0]  res;
    logic [2:0]  held;
    logic [2:0]  expq[$];
    int          lat;
    int          got_n;
    int          first_c;
    int          last_c;
    int          seen;

    vecs[0]  = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b100};
    vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b010};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b001};
    vecs[3]  = '{32'h00000000, 32'h00000000, 1'b1, 3'b100};
    vecs[4]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b010};
    vecs[5]  = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b001};
    vecs[6]  = '{32'h00000001, 32'h00000002, 1'b0, 3'b010};
    vecs[7]  = '{32'h12345678, 32'h12345679, 1'b1, 3'b010};
    vecs[8]  = '{32'h80000001, 32'h80000000, 1'b1, 3'b001};
    vecs[9]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3'b010};
    vecs[10] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 3'b001};
    vecs[11] = '{32'h00010000, 32'h0000FFFF, 1'b0, 3'b001};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; signed_mode = 1'b0;
`ifdef EQUAL_CMP_PIPE_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset eq/lt/gt", {29'd0, equal, less, greater}, 32'd0);

    // Single operations: latency, result, and immunity to a later signed_mode flip.
    for (int i = 0; i < 12; i++) begin
      apply_one(vecs[i].vx, vecs[i].vy, vecs[i].sm, res, lat);
      check($sformatf("vec%0d latency", i), lat, 32'd6);
      check($sformatf("vec%0d result", i), {29'd0, res}, {29'd0, vecs[i].exp});
      tick();
      check($sformatf("vec%0d retired", i), {31'd0, out_valid}, 32'd0);
    end

    // Ten back-to-back transfers must come out in order on consecutive cycles.
    got_n = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("tput extra result", {31'd0, out_valid}, 32'd0);
        end else begin
          check($sformatf("tput res%0d", got_n), {29'd0, equal, less, greater},
                {29'd0, expq.pop_front()});
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got_n++;
      end
      if (c < 10) begin
        x = 32'h1111_1111 * c;
        y = (c % 3 == 0) ? x : 32'h5555_5555;
        signed_mode = c[0];
        in_valid = 1'b1;
        expq.push_back(ref_cmp(x, y, signed_mode));
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    check("tput count", got_n, 32'd10);
    check("tput span", last_c - first_c, 32'd9);

    // Backpressure: stall 4 cycles with a result at the output and two behind it.
    for (int i = 0; i < 3; i++) begin
      x = 32'hA000_0000 + i; y = 32'hA000_0001; signed_mode = 1'b1; in_valid = 1'b1;
      expq.push_back(ref_cmp(x, y, signed_mode));
      tick();
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp first result", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b0;
    held = {equal, less, greater};
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp stall%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp stall%0d in_ready", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp stall%0d hold", i), {29'd0, equal, less, greater}, {29'd0, held});
    end
    out_ready = 1'b1;
    got_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("bp extra result", {31'd0, out_valid}, 32'd0);
        end else begin
          check($sformatf("bp res%0d", got_n), {29'd0, equal, less, greater},
                {29'd0, expq.pop_front()});
        end
        got_n++;
      end
      tick();
    end
    check("bp count", got_n, 32'd3);

    // Reset with three operations in flight plus a transfer during the reset edge.
    for (int i = 0; i < 3; i++) begin
      x = 32'h5 + i; y = 32'h5; signed_mode = 1'b0; in_valid = 1'b1;
      tick();
    end
    rst = 1'b1; x = 32'h7; y = 32'h7;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst eq/lt/gt", {29'd0, equal, less, greater}, 32'd0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid) seen++;
      tick();
    end
    check("midrst ghosts", seen, 32'd0);

`ifdef EQUAL_CMP_PIPE_STATS_EN
    check("stats after reset", eq_count, 32'd0);
    for (int i = 0; i < 5; i++) begin
      apply_one(32'h0000_0100, (i < 3) ? 32'h0000_0100 : 32'h0000_0200, 1'b0, res, lat);
      tick();
    end
    check("stats eq_count", eq_count, 32'd3);
    apply_one(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, res, lat);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stats clr priority", eq_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
